// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: N-channel request arbiter and data mux in front of ip_tx.
// Optional REQ/XFER watchdog enabled by `define IP_TX_ARB_TIMEOUT_EN.
module ip_tx_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      ch_tx_req,
  input  logic [NUM_CH-1:0]      ch_tx_ready,
  input  logic [8*NUM_CH-1:0]    ch_tx_data,
  input  logic [8*NUM_CH-1:0]    ch_proto,
  input  logic [16*NUM_CH-1:0]   ch_len,
  output logic [NUM_CH-1:0]      ch_tx_ack,
  input  logic                   ip_tx_ack,
  input  logic                   mac_send_end,
  output logic                   ip_tx_req,
  output logic                   ip_tx_ready,
  output logic [7:0]             ip_tx_data,
  output logic [7:0]             ip_send_type,
  output logic [15:0]            ip_send_data_length,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic [2:0]   rr_ptr;
  logic [2:0]   win_id;
  logic [7:0]   req_pad;
  logic [7:0]   rdy_pad;
  logic [63:0]  data_pad;
  logic [63:0]  proto_pad;
  logic [127:0] len_pad;
  logic [7:0]   ack_vec;
  logic         wd_fire;

  // Channel buses widened to the 8-channel maximum so a 3-bit index is exact
  assign req_pad   = 8'(ch_tx_req);
  assign rdy_pad   = 8'(ch_tx_ready);
  assign data_pad  = 64'(ch_tx_data);
  assign proto_pad = 64'(ch_proto);
  assign len_pad   = 128'(ch_len);
  assign ack_vec   = 8'd1 << grant_id;
  assign busy      = (state != S_IDLE);

  // Winner search: scan starts at rr_ptr (round-robin) or ch0 (priority)
  always_comb begin
    logic       found;
    logic [3:0] cand;
    win_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) begin
        cand = 4'(k);
      end else begin
        cand = {1'b0, rr_ptr} + 4'(k);
        if (cand >= 4'(NUM_CH))
          cand = cand - 4'(NUM_CH);
      end
      if (!found && req_pad[cand[2:0]]) begin
        found  = 1'b1;
        win_id = cand[2:0];
      end
    end
  end

  // Next-state: ack outranks a stale mac_send_end while in REQ
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (|ch_tx_req) state_nxt = S_REQ;
      S_REQ: begin
        if (ip_tx_ack)    state_nxt = S_XFER;
        else if (wd_fire) state_nxt = S_GAP;
      end
      S_XFER: if (mac_send_end || wd_fire) state_nxt = S_GAP;
      S_GAP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef IP_TX_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_hit;

  assign wd_hit  = ((state == S_REQ) || (state == S_XFER)) &&
                   (wd_cnt == 16'(TIMEOUT_CYC - 1));
  assign wd_fire = wd_hit &&
                   !((state == S_REQ) && ip_tx_ack) &&
                   !((state == S_XFER) && mac_send_end);

  // Watchdog counts cycles spent in one waiting state
  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt <= '0;
    else if (state_nxt != state)
      wd_cnt <= '0;
    else if ((state == S_REQ) || (state == S_XFER))
      wd_cnt <= wd_cnt + 16'd1;
  end

  // One-cycle error pulse coincides with the forced GAP
  always_ff @(posedge clk) begin
    if (rst)
      timeout_err <= 1'b0;
    else
      timeout_err <= wd_fire;
  end
`else
  logic cfg_unused;

  assign cfg_unused  = |16'(TIMEOUT_CYC);
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Grant latch, ip_tx handshake, data mux and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      rr_ptr              <= '0;
      grant_id            <= '0;
      ip_send_type        <= '0;
      ip_send_data_length <= '0;
      ip_tx_req           <= 1'b0;
      ch_tx_ack           <= '0;
      ip_tx_ready         <= 1'b0;
      ip_tx_data          <= '0;
    end else begin
      state       <= state_nxt;
      ch_tx_ack   <= '0;
      ip_tx_ready <= 1'b0;
      ip_tx_data  <= '0;
      unique case (state)
        S_IDLE: begin
          if (|ch_tx_req) begin
            grant_id            <= win_id;
            ip_send_type        <= proto_pad[{win_id, 3'b000} +: 8];
            ip_send_data_length <= len_pad[{win_id, 4'b0000} +: 16];
            ip_tx_req           <= 1'b1;
          end
        end
        S_REQ: begin
          if (ip_tx_ack) begin
            ip_tx_req <= 1'b0;
            ch_tx_ack <= ack_vec[NUM_CH-1:0];
          end else if (wd_fire) begin
            ip_tx_req <= 1'b0;
          end
        end
        S_XFER: begin
          if (!(mac_send_end || wd_fire)) begin
            ip_tx_ready <= rdy_pad[grant_id];
            ip_tx_data  <= data_pad[{grant_id, 3'b000} +: 8];
          end
        end
        S_GAP: begin
          rr_ptr <= (grant_id == 3'(NUM_CH - 1)) ? 3'd0
                                                 : grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb_ip_tx_arbiter: scoreboard bench for round-robin and fixed-priority arbiters.
// Timeout scenario active when IP_TX_ARB_TIMEOUT_EN is defined.
module tb_ip_tx_arbiter;

  typedef struct packed {
    logic [2:0]  gid;
    logic [7:0]  typ;
    logic [15:0] len;
  } grant_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [3:0]  rdy;
  logic [31:0] data;
  logic [31:0] proto;
  logic [63:0] len;
  logic        ack_i;
  logic        end_i;
  logic [3:0]  f_req_in;
  logic        f_ack_i;
  logic        f_end_i;

  logic [3:0]  r_ch_ack;
  logic        r_req;
  logic        r_rdy;
  logic [7:0]  r_data;
  logic [7:0]  r_type;
  logic [15:0] r_len;
  logic [2:0]  r_gid;
  logic        r_busy;
  logic        r_terr;

  logic [3:0]  f_ch_ack;
  logic        f_req;
  logic        f_rdy;
  logic [7:0]  f_data;
  logic [7:0]  f_type;
  logic [15:0] f_len;
  logic [2:0]  f_gid;
  logic        f_busy;
  logic        f_terr;

  int checks = 0;
  int errors = 0;

  grant_t     rexp_g[$];
  grant_t     fexp_g[$];
  logic [7:0] rexp_d[$];
  logic [7:0] fexp_d[$];
  grant_t     mg;
  logic [7:0] md;

  ip_tx_arbiter #(.NUM_CH(4), .ARB_MODE(0), .TIMEOUT_CYC(16)) u_rr (
    .clk(clk), .rst(rst),
    .ch_tx_req(req), .ch_tx_ready(rdy), .ch_tx_data(data),
    .ch_proto(proto), .ch_len(len), .ch_tx_ack(r_ch_ack),
    .ip_tx_ack(ack_i), .mac_send_end(end_i),
    .ip_tx_req(r_req), .ip_tx_ready(r_rdy), .ip_tx_data(r_data),
    .ip_send_type(r_type), .ip_send_data_length(r_len),
    .grant_id(r_gid), .busy(r_busy), .timeout_err(r_terr)
  );

  ip_tx_arbiter #(.NUM_CH(4), .ARB_MODE(1), .TIMEOUT_CYC(16)) u_fp (
    .clk(clk), .rst(rst),
    .ch_tx_req(f_req_in), .ch_tx_ready(rdy), .ch_tx_data(data),
    .ch_proto(proto), .ch_len(len), .ch_tx_ack(f_ch_ack),
    .ip_tx_ack(f_ack_i), .mac_send_end(f_end_i),
    .ip_tx_req(f_req), .ip_tx_ready(f_rdy), .ip_tx_data(f_data),
    .ip_send_type(f_type), .ip_send_data_length(f_len),
    .grant_id(f_gid), .busy(f_busy), .timeout_err(f_terr)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_req(input bit sel);
    return sel ? f_req : r_req;
  endfunction
  function automatic logic cur_rdy(input bit sel);
    return sel ? f_rdy : r_rdy;
  endfunction
  function automatic logic cur_busy(input bit sel);
    return sel ? f_busy : r_busy;
  endfunction
  function automatic logic [2:0] cur_gid(input bit sel);
    return sel ? f_gid : r_gid;
  endfunction
  function automatic logic [7:0] cur_type(input bit sel);
    return sel ? f_type : r_type;
  endfunction

  task automatic set_ack(input bit sel, input logic v);
    if (sel) f_ack_i = v; else ack_i = v;
  endtask
  task automatic set_end(input bit sel, input logic v);
    if (sel) f_end_i = v; else end_i = v;
  endtask

  task automatic drive_byte(input bit sel, input logic [2:0] gid,
                            input logic [7:0] b);
    rdy  = 4'hF;
    data = {4{8'hEE}};
    data[int'(gid)*8 +: 8] = b;
    if (sel) fexp_d.push_back(b); else rexp_d.push_back(b);
  endtask

  // One full frame: wait for request, ack, stream bytes, end, check GAP
  task automatic frame(input bit sel, input logic [2:0] gid,
                       input int nbytes, input logic [7:0] base,
                       input logic [3:0] req_after, input bit ack_end);
    bit seen;
    grant_t g;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = cur_req(sel);
    end
    chk("req_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("req_gid", 32'(cur_gid(sel)), 32'(gid));
    g.gid = gid;
    g.typ = proto[int'(gid)*8 +: 8];
    g.len = len[int'(gid)*16 +: 16];
    if (sel) fexp_g.push_back(g); else rexp_g.push_back(g);
    @(posedge clk); #1;
    set_ack(sel, 1'b1);
    if (ack_end) set_end(sel, 1'b1);
    @(posedge clk); #1;
    set_ack(sel, 1'b0);
    set_end(sel, 1'b0);
    drive_byte(sel, gid, base);
    @(negedge clk);
    chk("req_drop", 32'(cur_req(sel)), 32'd0);
    chk("rdy_lat", 32'(cur_rdy(sel)), 32'd0);
    for (int i = 1; i < nbytes; i++) begin
      @(posedge clk); #1;
      drive_byte(sel, gid, base + 8'(i));
      @(negedge clk);
      chk("rdy_stream", 32'(cur_rdy(sel)), 32'd1);
    end
    @(posedge clk); #1;
    rdy  = 4'hF & ~(4'd1 << gid);
    data = {4{8'h5A}};
    @(posedge clk); #1;
    rdy = 4'h0;
    if (sel) f_req_in = req_after; else req = req_after;
    set_end(sel, 1'b1);
    @(posedge clk); #1;
    set_end(sel, 1'b0);
    @(negedge clk);
    chk("gap_busy", 32'(cur_busy(sel)), 32'd1);
    chk("gap_rdy", 32'(cur_rdy(sel)), 32'd0);
    chk("gap_type", 32'(cur_type(sel)), 32'(g.typ));
    @(negedge clk);
    chk("idle_busy", 32'(cur_busy(sel)), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every ack pulse and every valid byte is matched against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (r_ch_ack != 4'h0) begin
        if (rexp_g.size() == 0) begin
          chk("rr_ack_unexpected", 32'(r_ch_ack), 32'd0);
        end else begin
          mg = rexp_g.pop_front();
          chk("rr_ack_vec", 32'(r_ch_ack), 32'd1 << mg.gid);
          chk("rr_gid", 32'(r_gid), 32'(mg.gid));
          chk("rr_type", 32'(r_type), 32'(mg.typ));
          chk("rr_len", 32'(r_len), 32'(mg.len));
        end
      end
      if (r_rdy) begin
        if (rexp_d.size() == 0) begin
          chk("rr_data_unexpected", 32'(r_data), 32'hFFFF);
        end else begin
          md = rexp_d.pop_front();
          chk("rr_data", 32'(r_data), 32'(md));
        end
      end
      if (f_ch_ack != 4'h0) begin
        if (fexp_g.size() == 0) begin
          chk("fp_ack_unexpected", 32'(f_ch_ack), 32'd0);
        end else begin
          mg = fexp_g.pop_front();
          chk("fp_ack_vec", 32'(f_ch_ack), 32'd1 << mg.gid);
          chk("fp_gid", 32'(f_gid), 32'(mg.gid));
          chk("fp_type", 32'(f_type), 32'(mg.typ));
          chk("fp_len", 32'(f_len), 32'(mg.len));
        end
      end
      if (f_rdy) begin
        if (fexp_d.size() == 0) begin
          chk("fp_data_unexpected", 32'(f_data), 32'hFFFF);
        end else begin
          md = fexp_d.pop_front();
          chk("fp_data", 32'(f_data), 32'(md));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int rq;
    int er;
    bit seen;
    grant_t g;
    rst      = 1'b1;
    req      = 4'h0;
    rdy      = 4'h0;
    data     = '0;
    proto    = {8'h01, 8'h11, 8'h01, 8'h11};
    len      = {16'd1500, 16'd40, 16'd64, 16'd28};
    ack_i    = 1'b0;
    end_i    = 1'b0;
    f_req_in = 4'h0;
    f_ack_i  = 1'b0;
    f_end_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(r_req), 32'd0);
    chk("rst_ack", 32'(r_ch_ack), 32'd0);
    chk("rst_rdy", 32'(r_rdy), 32'd0);
    chk("rst_data", 32'(r_data), 32'd0);
    chk("rst_type", 32'(r_type), 32'd0);
    chk("rst_len", 32'(r_len), 32'd0);
    chk("rst_gid", 32'(r_gid), 32'd0);
    chk("rst_busy", 32'(r_busy), 32'd0);
    chk("rst_terr", 32'(r_terr), 32'd0);
    chk("rst_fp_busy", 32'(f_busy), 32'd0);

    // single channel 2
    @(posedge clk); #1;
    req = 4'b0100;
    @(negedge clk);
    chk("t1_req_early", 32'(r_req), 32'd0);
    @(negedge clk);
    chk("t1_req", 32'(r_req), 32'd1);
    chk("t1_gid", 32'(r_gid), 32'd2);
    chk("t1_type", 32'(r_type), 32'h11);
    chk("t1_len", 32'(r_len), 32'd40);
    frame(1'b0, 3'd2, 4, 8'h10, 4'h0, 1'b0);

    // round-robin over all four, then wrap
    do_reset();
    @(posedge clk); #1;
    req = 4'hF;
    frame(1'b0, 3'd0, 2, 8'h20, 4'hF, 1'b0);
    frame(1'b0, 3'd1, 2, 8'h30, 4'hF, 1'b0);
    frame(1'b0, 3'd2, 2, 8'h40, 4'hF, 1'b0);
    frame(1'b0, 3'd3, 2, 8'h50, 4'hF, 1'b0);
    frame(1'b0, 3'd0, 2, 8'h60, 4'h0, 1'b0);

    // reset mid-frame clears state and rr_ptr
    @(posedge clk); #1;
    req  = 4'b1001;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = r_req;
    end
    chk("t5_req_seen", 32'(seen), 32'd1);
    chk("t5_gid", 32'(r_gid), 32'd3);
    g.gid = 3'd3;
    g.typ = 8'h01;
    g.len = 16'd1500;
    rexp_g.push_back(g);
    @(posedge clk); #1;
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(r_busy), 32'd0);
    chk("t5_gid0", 32'(r_gid), 32'd0);
    chk("t5_req0", 32'(r_req), 32'd0);
    chk("t5_ack0", 32'(r_ch_ack), 32'd0);
    chk("t5_type0", 32'(r_type), 32'd0);
    chk("t5_len0", 32'(r_len), 32'd0);
    frame(1'b0, 3'd0, 3, 8'h70, 4'h0, 1'b0);

    // fixed priority instance
    @(posedge clk); #1;
    f_req_in = 4'b1010;
    frame(1'b1, 3'd1, 2, 8'hA0, 4'b1010, 1'b0);
    frame(1'b1, 3'd1, 2, 8'hB0, 4'b1000, 1'b0);
    frame(1'b1, 3'd3, 2, 8'hC0, 4'h0, 1'b0);

    // ack and stale mac_send_end together in REQ
    @(posedge clk); #1;
    req = 4'b1001;
    frame(1'b0, 3'd3, 3, 8'h90, 4'h0, 1'b1);

`ifdef IP_TX_ARB_TIMEOUT_EN
    @(posedge clk); #1;
    req = 4'b0100;
    rq = 0;
    er = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (r_req) begin
        rq++;
        req = 4'h0;
      end
      if (r_terr) begin
        er++;
        chk("to_busy", 32'(r_busy), 32'd1);
        chk("to_req", 32'(r_req), 32'd0);
      end
    end
    chk("to_req_cycles", 32'(rq), 32'd16);
    chk("to_err_pulses", 32'(er), 32'd1);
    chk("to_idle", 32'(r_busy), 32'd0);
    chk("to_gid", 32'(r_gid), 32'd2);
`else
    @(posedge clk); #1;
    req = 4'b0100;
    rq = 0;
    for (int n = 0; n < 21; n++) begin
      @(negedge clk);
      if (r_req) begin
        rq++;
        req = 4'h0;
      end
    end
    chk("hold_req_cycles", 32'(rq), 32'd20);
    chk("hold_terr", 32'(r_terr), 32'd0);
    frame(1'b0, 3'd2, 2, 8'hD0, 4'h0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_rr_grants_left", 32'(rexp_g.size()), 32'd0);
    chk("sb_rr_data_left", 32'(rexp_d.size()), 32'd0);
    chk("sb_fp_grants_left", 32'(fexp_g.size()), 32'd0);
    chk("sb_fp_data_left", 32'(fexp_d.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
